// File: rtl/c880_if.sv
// c880_if - signal bundle between the c880 block and its environment.
// G1..G60 are the operand, opcode, mask and control inputs to the block;
// G855..G880 are the registered results and flags it returns.
interface c880_if;
  logic G1,  G2,  G3,  G4,  G5,  G6,  G7,  G8;
  logic G9,  G10, G11, G12, G13, G14, G15, G16;
  logic G17, G18, G19, G20, G21, G22, G23, G24;
  logic G25, G26, G27, G28, G29, G30, G31, G32;
  logic G33, G34, G35, G36, G37, G38, G39, G40;
  logic G41, G42, G43, G44, G45, G46, G47, G48;
  logic G49, G50, G51, G52, G53, G54, G55, G56;
  logic G57, G58, G59, G60;
  logic G855, G856, G857, G858, G859, G860, G861, G862;
  logic G863, G864, G865, G866, G867, G868, G869, G870;
  logic G871, G872, G873, G874, G875, G876, G877, G878, G879, G880;

  modport master (
    output G1,  G2,  G3,  G4,  G5,  G6,  G7,  G8,
           G9,  G10, G11, G12, G13, G14, G15, G16,
           G17, G18, G19, G20, G21, G22, G23, G24,
           G25, G26, G27, G28, G29, G30, G31, G32,
           G33, G34, G35, G36, G37, G38, G39, G40,
           G41, G42, G43, G44, G45, G46, G47, G48,
           G49, G50, G51, G52, G53, G54, G55, G56,
           G57, G58, G59, G60,
    input  G855, G856, G857, G858, G859, G860, G861, G862,
           G863, G864, G865, G866, G867, G868, G869, G870,
           G871, G872, G873, G874, G875, G876, G877, G878, G879, G880
  );

  modport slave (
    input  G1,  G2,  G3,  G4,  G5,  G6,  G7,  G8,
           G9,  G10, G11, G12, G13, G14, G15, G16,
           G17, G18, G19, G20, G21, G22, G23, G24,
           G25, G26, G27, G28, G29, G30, G31, G32,
           G33, G34, G35, G36, G37, G38, G39, G40,
           G41, G42, G43, G44, G45, G46, G47, G48,
           G49, G50, G51, G52, G53, G54, G55, G56,
           G57, G58, G59, G60,
    output G855, G856, G857, G858, G859, G860, G861, G862,
           G863, G864, G865, G866, G867, G868, G869, G870,
           G871, G872, G873, G874, G875, G876, G877, G878, G879, G880
  );
endinterface

// File: rtl/c880.sv
// c880 - dual 8-bit ALU (units X and Y) with masked second operands,
// carry/zero/parity/overflow flags and optional A-vs-B comparator.
// All outputs are registered and updated only on edges with load enable.
// Optional feature macro: C880_CMP_EN (adds EQ/GT comparator; when it is
// undefined EQ and GT are tied to 0 and the signed-compare select is unused).
module c880 (
  input logic CK,
  input logic RST_N,
  c880_if.slave bus
);

  logic [7:0] w_a, w_b, w_c, w_d, w_mx, w_my;
  logic [2:0] w_opx, w_opy;
  logic       w_cix, w_ciy, w_ld, w_invx, w_invy;
  logic [9:0] w_resx, w_resy;
  logic       w_eq, w_gt;

  logic [7:0] r_rx, r_ry;
  logic       r_cx, r_cy, r_zx, r_zy, r_px, r_py, r_vx, r_vy, r_eq, r_gt;

  assign w_a    = {bus.G8,  bus.G7,  bus.G6,  bus.G5,  bus.G4,  bus.G3,  bus.G2,  bus.G1};
  assign w_b    = {bus.G16, bus.G15, bus.G14, bus.G13, bus.G12, bus.G11, bus.G10, bus.G9};
  assign w_c    = {bus.G24, bus.G23, bus.G22, bus.G21, bus.G20, bus.G19, bus.G18, bus.G17};
  assign w_d    = {bus.G32, bus.G31, bus.G30, bus.G29, bus.G28, bus.G27, bus.G26, bus.G25};
  assign w_opx  = {bus.G35, bus.G34, bus.G33};
  assign w_opy  = {bus.G38, bus.G37, bus.G36};
  assign w_cix  = bus.G39;
  assign w_ciy  = bus.G40;
  assign w_mx   = {bus.G48, bus.G47, bus.G46, bus.G45, bus.G44, bus.G43, bus.G42, bus.G41};
  assign w_my   = {bus.G56, bus.G55, bus.G54, bus.G53, bus.G52, bus.G51, bus.G50, bus.G49};
  assign w_ld   = bus.G57;
  assign w_invx = bus.G58;
  assign w_invy = bus.G59;

  // One ALU slice; returns {overflow, carry, result[7:0]}.  SUB is an add of
  // the inverted operand, so overflow uses the operand actually summed.
  function automatic logic [9:0] aluOp(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op, input logic ci);
    logic [8:0] s;
    logic [7:0] bb;
    logic [7:0] r;
    logic       c;
    logic       v;
    s  = 9'd0;
    bb = 8'd0;
    r  = 8'd0;
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      3'b000, 3'b001: begin
        bb = op[0] ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + {8'd0, ci};
        r  = s[7:0];
        c  = s[8];
        v  = (a[7] == bb[7]) && (r[7] != a[7]);
      end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b101: r = ~a;
      3'b110: begin
        r = {a[6:0], ci};
        c = a[7];
      end
      default: begin
        r = {ci, a[7:1]};
        c = a[0];
      end
    endcase
    return {v, c, r};
  endfunction

  // Both ALU units work on their masked second operand.
  always_comb begin
    w_resx = aluOp(w_a, w_b & w_mx, w_opx, w_cix);
    w_resy = aluOp(w_c, w_d & w_my, w_opy, w_ciy);
  end

`ifdef C880_CMP_EN
  // Comparator on the unmasked A and B; G60 selects signed ordering.
  always_comb begin
    w_eq = (w_a == w_b);
    w_gt = bus.G60 ? ($signed(w_a) > $signed(w_b)) : (w_a > w_b);
  end
`else
  assign w_eq = 1'b0;
  assign w_gt = 1'b0;
`endif

  // Output register: synchronous clear, otherwise load on LD and hold
  // otherwise.  Zero/parity look at the result before inversion.
  always_ff @(posedge CK) begin
    if (!RST_N) begin
      r_rx <= 8'd0;
      r_ry <= 8'd0;
      r_cx <= 1'b0;
      r_cy <= 1'b0;
      r_zx <= 1'b0;
      r_zy <= 1'b0;
      r_px <= 1'b0;
      r_py <= 1'b0;
      r_vx <= 1'b0;
      r_vy <= 1'b0;
      r_eq <= 1'b0;
      r_gt <= 1'b0;
    end else if (w_ld) begin
      r_rx <= w_resx[7:0] ^ {8{w_invx}};
      r_ry <= w_resy[7:0] ^ {8{w_invy}};
      r_cx <= w_resx[8];
      r_cy <= w_resy[8];
      r_zx <= (w_resx[7:0] == 8'd0);
      r_zy <= (w_resy[7:0] == 8'd0);
      r_px <= ^w_resx[7:0];
      r_py <= ^w_resy[7:0];
      r_vx <= w_resx[9];
      r_vy <= w_resy[9];
      r_eq <= w_eq;
      r_gt <= w_gt;
    end
  end

  assign {bus.G862, bus.G861, bus.G860, bus.G859,
          bus.G858, bus.G857, bus.G856, bus.G855} = r_rx;
  assign {bus.G870, bus.G869, bus.G868, bus.G867,
          bus.G866, bus.G865, bus.G864, bus.G863} = r_ry;
  assign {bus.G880, bus.G879, bus.G878, bus.G877, bus.G876,
          bus.G875, bus.G874, bus.G873, bus.G872, bus.G871} =
         {r_vy, r_vx, r_gt, r_eq, r_py, r_px, r_zy, r_zx, r_cy, r_cx};

endmodule

// File: tb/tb_c880.sv
// tb_c880 - directed self-checking bench for c880.
// Expected output words are hand-computed; EQ/GT expectations follow
// whether C880_CMP_EN is defined for this build.
module tb_c880;

`ifdef C880_CMP_EN
  localparam logic CMP = 1'b1;
`else
  localparam logic CMP = 1'b0;
`endif

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic CK;
  logic RST_N;
  c880_if bus ();

  c880 dut (
    .CK    (CK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  logic [7:0] a, b, c, d, mx, my;
  logic [2:0] opx, opy;
  logic       cix, ciy, ld, invx, invy, sgn;

  int checks = 0;
  int errors = 0;

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Pack expected fields in the same order as observeAll below.
  function automatic logic [25:0] packOut(input logic [7:0] rx, input logic [7:0] ry,
                                          input logic cx, input logic cy,
                                          input logic zx, input logic zy,
                                          input logic px, input logic py,
                                          input logic eq, input logic gt,
                                          input logic vx, input logic vy);
    return {vy, vx, gt, eq, py, px, zy, zx, cy, cx, ry, rx};
  endfunction

  function automatic logic [25:0] observeAll();
    return {bus.G880, bus.G879, bus.G878, bus.G877, bus.G876,
            bus.G875, bus.G874, bus.G873, bus.G872, bus.G871,
            bus.G870, bus.G869, bus.G868, bus.G867,
            bus.G866, bus.G865, bus.G864, bus.G863,
            bus.G862, bus.G861, bus.G860, bus.G859,
            bus.G858, bus.G857, bus.G856, bus.G855};
  endfunction

  // Copy the stimulus variables onto the interface pins.
  task automatic applyStimulus();
    {bus.G8,  bus.G7,  bus.G6,  bus.G5,  bus.G4,  bus.G3,  bus.G2,  bus.G1}  = a;
    {bus.G16, bus.G15, bus.G14, bus.G13, bus.G12, bus.G11, bus.G10, bus.G9}  = b;
    {bus.G24, bus.G23, bus.G22, bus.G21, bus.G20, bus.G19, bus.G18, bus.G17} = c;
    {bus.G32, bus.G31, bus.G30, bus.G29, bus.G28, bus.G27, bus.G26, bus.G25} = d;
    {bus.G35, bus.G34, bus.G33} = opx;
    {bus.G38, bus.G37, bus.G36} = opy;
    bus.G39 = cix;
    bus.G40 = ciy;
    {bus.G48, bus.G47, bus.G46, bus.G45, bus.G44, bus.G43, bus.G42, bus.G41} = mx;
    {bus.G56, bus.G55, bus.G54, bus.G53, bus.G52, bus.G51, bus.G50, bus.G49} = my;
    bus.G57 = ld;
    bus.G58 = invx;
    bus.G59 = invy;
    bus.G60 = sgn;
  endtask

  // Apply inputs, clock one edge, then sample 1 time unit after the edge.
  task automatic tick();
    applyStimulus();
    @(posedge CK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [25:0] expected);
    logic [25:0] observed;
    observed = observeAll();
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%07h expected=%07h", tag, observed, expected);
    end
  endtask

  task automatic invertInputs();
    a = ~a; b = ~b; c = ~c; d = ~d; mx = ~mx; my = ~my;
    opx = ~opx; opy = ~opy; cix = ~cix; ciy = ~ciy;
    invx = ~invx; invy = ~invy; sgn = ~sgn;
  endtask

  initial begin
    // Reset with every input high, LD included.
    RST_N = 1'b0;
    a = 8'hFF; b = 8'hFF; c = 8'hFF; d = 8'hFF; mx = 8'hFF; my = 8'hFF;
    opx = 3'b111; opy = 3'b111; cix = 1'b1; ciy = 1'b1;
    ld = 1'b1; invx = 1'b1; invy = 1'b1; sgn = 1'b1;
    tick();
    checkOutput("reset_all_ones", 26'd0);

    // X: FF + 01 wraps to 00 with carry, no signed overflow.
    RST_N = 1'b1;
    a = 8'hFF; b = 8'h01; mx = 8'hFF; opx = OP_ADD; cix = 1'b0;
    c = 8'h00; d = 8'h00; my = 8'h00; opy = OP_ADD; ciy = 1'b0;
    invx = 1'b0; invy = 1'b0; sgn = 1'b0; ld = 1'b1;
    tick();
    checkOutput("add_ff_01", packOut(8'h00, 8'h00, 1, 0, 1, 1, 0, 0, 0, CMP, 0, 0));

    // X: 7F + 01 = 80 signed overflow; Y: 3C ^ F0 = CC.
    a = 8'h7F; b = 8'h01;
    c = 8'h3C; d = 8'hF0; my = 8'hFF; opy = OP_XOR;
    tick();
    checkOutput("add_7f_01", packOut(8'h80, 8'hCC, 0, 0, 0, 0, 1, 0, 0, CMP, 1, 0));

    // Same with X inverted: RX becomes 7F, parity still from 80.
    invx = 1'b1;
    tick();
    checkOutput("add_7f_01_inv", packOut(8'h7F, 8'hCC, 0, 0, 0, 0, 1, 0, 0, CMP, 1, 0));

    // X: 05 - 05 with CIX=1 -> 5 + FA + 1 = 0x100.
    invx = 1'b0; a = 8'h05; b = 8'h05; mx = 8'hFF; opx = OP_SUB; cix = 1'b1;
    tick();
    checkOutput("sub_05_05", packOut(8'h00, 8'hCC, 1, 0, 1, 0, 0, 0, CMP, 0, 0, 0));

    // Masked B: 5 + ~00 + 1 = 0x105; EQ still compares unmasked A/B.
    mx = 8'h00;
    tick();
    checkOutput("sub_masked", packOut(8'h05, 8'hCC, 1, 0, 0, 0, 0, 0, CMP, 0, 0, 0));

    // Masked B with ADD: 5 + 0 + 1 = 06.
    opx = OP_ADD;
    tick();
    checkOutput("add_masked", packOut(8'h06, 8'hCC, 0, 0, 0, 0, 0, 0, CMP, 0, 0, 0));

    // GT on 80 vs 01: unsigned greater, signed smaller.  X: 80 & 01 = 00.
    a = 8'h80; b = 8'h01; mx = 8'hFF; opx = OP_AND; cix = 1'b0; sgn = 1'b0;
    tick();
    checkOutput("gt_unsigned", packOut(8'h00, 8'hCC, 0, 0, 1, 0, 0, 0, 0, CMP, 0, 0));
    sgn = 1'b1;
    tick();
    checkOutput("gt_signed", packOut(8'h00, 8'hCC, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

    // X: SHL 81 with CIX=1 -> 03, carry 1; Y: SHR 81 with CIY=0 -> 40, carry 1.
    sgn = 1'b0; a = 8'h81; b = 8'h81; opx = OP_SHL; cix = 1'b1;
    c = 8'h81; opy = OP_SHR; ciy = 1'b0;
    tick();
    checkOutput("shifts", packOut(8'h03, 8'h40, 1, 1, 0, 0, 0, 1, CMP, 0, 0, 0));

    // X: NOT 0F = F0; Y: 00 - 01 with CIY=1 = FF, no carry, inverted to 00
    // while ZY reflects the pre-inversion FF.
    a = 8'h0F; b = 8'h0F; opx = OP_NOT; cix = 1'b0;
    c = 8'h00; d = 8'h01; my = 8'hFF; opy = OP_SUB; ciy = 1'b1; invy = 1'b1;
    tick();
    checkOutput("not_sub_invy", packOut(8'hF0, 8'h00, 0, 0, 0, 0, 0, 0, CMP, 0, 0, 0));

    // X: 50 | 0A = 5A; Y: 80 + 80 = 0x100, carry and signed overflow.
    a = 8'h50; b = 8'h0A; mx = 8'hFF; opx = OP_OR;
    c = 8'h80; d = 8'h80; my = 8'hFF; opy = OP_ADD; ciy = 1'b0; invy = 1'b0;
    tick();
    checkOutput("or_add_ovf", packOut(8'h5A, 8'h00, 0, 1, 0, 1, 0, 0, 0, CMP, 0, 1));

    // Hold: LD low with every other input toggled for three edges.
    ld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      invertInputs();
      tick();
      checkOutput($sformatf("hold_%0d", i),
                  packOut(8'h5A, 8'h00, 0, 1, 0, 1, 0, 0, 0, CMP, 0, 1));
    end

    // Reset while a load is pending clears everything.
    a = 8'hFF; b = 8'h01; mx = 8'hFF; opx = OP_ADD; cix = 1'b0;
    c = 8'h00; d = 8'h00; my = 8'h00; opy = OP_ADD; ciy = 1'b0;
    invx = 1'b0; invy = 1'b0; sgn = 1'b0; ld = 1'b1;
    RST_N = 1'b0;
    tick();
    checkOutput("reset_with_ld", 26'd0);

    // First edge after reset release loads.
    RST_N = 1'b1;
    tick();
    checkOutput("reload", packOut(8'h00, 8'h00, 1, 0, 1, 1, 0, 0, 0, CMP, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
